// File: rtl/gb_vector_reader_pkg.sv
// Shared constants and state encoding for the global-buffer vector reader.
package gb_vector_reader_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int GB_ADDR_WIDTH = 7;
  localparam int VEC_LEN_MAX   = 100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gbr_state_e;

endpackage

// File: rtl/gb_vector_reader_gb_rd_skid_fifo.sv
// Two-entry FIFO holding returned read data plus its last flag; the head is
// driven straight from storage so out_ready never reaches out_data.
module gb_rd_skid_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic [1:0]   count
);

  logic [1:0][W:0] mem_q, mem_d;
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            push, pop;

  assign out_valid             = (cnt_q != 2'd0);
  assign {out_last, out_data}  = mem_q[rd_ptr_q];
  assign count                 = cnt_q;

  // The reader's credit check keeps pushes off a full FIFO; the guard is a backstop.
  assign push = in_valid && (cnt_q != 2'd2);
  assign pop  = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_last, in_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/gb_vector_reader.sv
// Streams a vector out of the global buffer num_passes times, one element per
// cycle when the consumer keeps up, through a 2-entry output FIFO.
module gb_vector_reader #(
  parameter int DATA_WIDTH       = gb_vector_reader_pkg::DATA_WIDTH,
  parameter int GB_ADDR_WIDTH    = gb_vector_reader_pkg::GB_ADDR_WIDTH,
  parameter int MAX_PASSES_WIDTH = 9
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [GB_ADDR_WIDTH-1:0]    vec_len,
  input  logic [MAX_PASSES_WIDTH-1:0] num_passes,
  output logic                        gb_rd_en,
  output logic [GB_ADDR_WIDTH-1:0]    gb_rd_addr,
  input  logic [DATA_WIDTH-1:0]       gb_rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);
  import gb_vector_reader_pkg::*;

  gbr_state_e                  state_q, state_d;
  logic [GB_ADDR_WIDTH-1:0]    len_q, len_d;
  logic [GB_ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [MAX_PASSES_WIDTH-1:0] npass_q, npass_d;
  logic [MAX_PASSES_WIDTH-1:0] pass_q, pass_d;
  logic                        inflight_q, inflight_d;
  logic                        inflight_last_q, inflight_last_d;
  logic                        done_q, done_d;

  logic       rd_en, rd_last, credit, pop;
  logic [1:0] fifo_cnt;

  assign rd_last = (addr_q == len_q - GB_ADDR_WIDTH'(1));
  assign pop     = out_valid && out_ready;
  // A slot freed by this cycle's pop counts as available, which keeps the
  // stream at full rate without ever exceeding two entries.
  assign credit  = ({1'b0, fifo_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    npass_d  = npass_q;
    pass_d   = pass_q;
    rd_en    = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (vec_len != '0 && num_passes != '0) begin
            state_d = ST_RUN;
            len_d   = vec_len;
            npass_d = num_passes;
            addr_d  = '0;
            pass_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (credit) begin
          rd_en = 1'b1;
          if (rd_last) begin
            addr_d = '0;
            pass_d = pass_q + MAX_PASSES_WIDTH'(1);
            if (pass_q == npass_q - MAX_PASSES_WIDTH'(1)) state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + GB_ADDR_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Final element leaves on this handshake: finish in the same edge.
        if (pop && fifo_cnt == 2'd1 && !inflight_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    inflight_d      = rd_en;
    inflight_last_d = rd_en && rd_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      len_q           <= '0;
      addr_q          <= '0;
      npass_q         <= '0;
      pass_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      addr_q          <= addr_d;
      npass_q         <= npass_d;
      pass_q          <= pass_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  assign gb_rd_en   = rd_en;
  assign gb_rd_addr = addr_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

  gb_rd_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_q),
    .in_data   (gb_rd_data),
    .in_last   (inflight_last_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_gb_vector_reader.sv
// Scoreboard bench: jobs push expected streams built from the buffer image;
// a monitor pops and compares on every handshake.
module tb_gb_vector_reader;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int PW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] vec_len = '0;
  logic [PW-1:0] num_passes = '0;
  logic          gb_rd_en;
  logic [AW-1:0] gb_rd_addr;
  logic [DW-1:0] gb_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:127];
  typedef struct { logic [DW-1:0] data; logic last; } exp_t;
  exp_t sb [$];
  int   acc_cnt = 0;
  int   ready_mode = 0;

  gb_vector_reader #(.DATA_WIDTH(DW), .GB_ADDR_WIDTH(AW), .MAX_PASSES_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .num_passes(num_passes),
    .gb_rd_en(gb_rd_en), .gb_rd_addr(gb_rd_addr), .gb_rd_data(gb_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Global buffer: data appears one cycle after the strobe.
  always @(posedge clk) if (gb_rd_en) gb_rd_data <= mem[gb_rd_addr];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer readiness patterns: 0 always ready, 1 toggle with low bursts, 2 random.
  initial begin
    int burst = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: begin
          if (burst > 0) begin out_ready = 1'b0; burst--; end
          else begin
            out_ready = ~out_ready;
            if ($urandom_range(0, 7) == 0) burst = $urandom_range(1, 5);
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshake compare, stall stability, no reads while idle.
  initial begin
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 0;
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk(out_valid == 1'b1, "stall_valid_hold", out_valid, 1);
          chk(out_data == prev_data && out_last == prev_last, "stall_data_hold", out_data, prev_data);
        end
        if (!busy) chk(gb_rd_en == 1'b0, "idle_no_read", gb_rd_en, 0);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_element", out_data, 0);
          end else begin
            e = sb.pop_front();
            chk(out_data == e.data, "elem_data", out_data, e.data);
            chk(out_last == e.last, "elem_last", out_last, e.last);
          end
          acc_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic push_expected(input int len, input int np);
    for (int p = 0; p < np; p++)
      for (int i = 0; i < len; i++) begin
        exp_t e;
        e.data = mem[i];
        e.last = (i == len - 1);
        sb.push_back(e);
      end
  endtask

  // Runs one job; exp_n (if nonzero) is the expected negedge count from start acceptance to done.
  task automatic run_job(input int len, input int np, input int exp_n, input bit again);
    int n = 0;
    @(posedge clk); #1;
    start = 1'b1; vec_len = AW'(len); num_passes = PW'(np);
    if (len != 0 && np != 0) push_expected(len, np);
    @(posedge clk); #1;
    start = again;
    vec_len = again ? AW'(7) : AW'($urandom);
    num_passes = PW'($urandom_range(1, 4));
    while (1) begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (done) break;
      if (n > 5000) begin chk(1'b0, "done_timeout", n, exp_n); break; end
    end
    if (exp_n != 0) chk(n == exp_n, "done_latency", n, exp_n);
    chk(busy == 1'b0, "busy_low_at_done", busy, 0);
    chk(sb.size() == 0, "all_elems_seen_at_done", sb.size(), 0);
    @(negedge clk);
    chk(done == 1'b0, "done_one_cycle", done, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(gb_rd_en == 0,   {tag, "_rd_en"}, gb_rd_en, 0);
    chk(gb_rd_addr == 0, {tag, "_rd_addr"}, gb_rd_addr, 0);
    chk(out_valid == 0,  {tag, "_out_valid"}, out_valid, 0);
    chk(out_data == 0,   {tag, "_out_data"}, out_data, 0);
    chk(out_last == 0,   {tag, "_out_last"}, out_last, 0);
    chk(busy == 0,       {tag, "_busy"}, busy, 0);
    chk(done == 0,       {tag, "_done"}, done, 0);
  endtask

  initial begin
    logic [DW-1:0] pat [0:4];
    int n;
    pat[0] = 16'h0080; pat[1] = 16'h0020; pat[2] = 16'h0040; pat[3] = 16'h0100; pat[4] = 16'h00A0;
    for (int i = 0; i < 128; i++) mem[i] = pat[i % 5];

    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full vector, consumer always ready; also probe first-valid latency.
    ready_mode = 0;
    @(posedge clk); #1;
    start = 1'b1; vec_len = AW'(100); num_passes = PW'(1);
    push_expected(100, 1);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); chk(out_valid == 0, "first_valid_c1", out_valid, 0);
    @(negedge clk); chk(out_valid == 0, "first_valid_c2_pre", out_valid, 0);
    @(negedge clk); chk(out_valid == 1, "first_valid_c2", out_valid, 1);
    chk(out_data == 16'h0080, "first_data", out_data, 16'h0080);
    n = 3;
    while (!done && n < 5000) begin @(negedge clk); n++; end
    chk(n == 103, "full_vec_latency", n, 103);
    chk(sb.size() == 0, "full_vec_drained", sb.size(), 0);

    run_job(5, 3, 18, 0);
    ready_mode = 1; run_job(10, 2, 0, 0);
    ready_mode = 0; run_job(1, 1, 4, 1);
    repeat (4) @(negedge clk);

    run_job(0, 3, 1, 0);
    run_job(4, 0, 1, 0);

    // Reset part-way through a long job.
    acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; vec_len = AW'(100); num_passes = PW'(1);
    push_expected(100, 1);
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (acc_cnt < 37 && n < 1000) begin @(negedge clk); n++; end
    chk(acc_cnt == 37, "accepted_before_reset", acc_cnt, 37);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk(out_valid == 0 && busy == 0, "quiet_after_reset", {out_valid, busy}, 0);
    run_job(100, 1, 103, 0);

    // Randomized jobs over a random buffer image.
    for (int i = 0; i < 128; i++) mem[i] = DW'($urandom);
    for (int j = 0; j < 8; j++) begin
      ready_mode = $urandom_range(1, 2);
      run_job($urandom_range(1, 20), $urandom_range(1, 3), 0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_vector_reader.md
GB_VECTOR_READER -- requirements
Module: gb_vector_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 16, meaning Q8.8 element width.
REQ-002 Parameter GB_ADDR_WIDTH, default 7, meaning global-buffer address width.
REQ-003 Parameter MAX_PASSES_WIDTH, default 9, meaning width of the pass-count input (covers 376 matrix rows).
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse starting a read job; ignored unless idle.
REQ-007 vec_len  input  GB_ADDR_WIDTH  element count per pass (1..100), sampled on accepted start.
REQ-008 num_passes  input  MAX_PASSES_WIDTH  number of full sweeps of the vector (>=1), sampled on accepted start.
REQ-009 gb_rd_en  output  1  global-buffer read strobe.
REQ-010 gb_rd_addr  output  GB_ADDR_WIDTH  global-buffer read address.
REQ-011 gb_rd_data  input  DATA_WIDTH  read data, valid exactly one cycle after gb_rd_en.
REQ-012 out_valid  output  1  streamed element valid.
REQ-013 out_ready  input  1  consumer (PE array) accepts element when out_valid && out_ready.
REQ-014 out_data  output  DATA_WIDTH  element value.
REQ-015 out_last  output  1  marks final element of a pass.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse after final element of final pass is accepted.

Function
REQ-018 States IDLE, RUN, DRAIN; IDLE->RUN on start with vec_len!=0 and num_passes!=0; start with either zero -> done pulse next cycle, remain IDLE.
REQ-019 RUN issues reads addr 0..vec_len-1, wrapping to 0 for each subsequent pass; RUN->DRAIN after last read of last pass issued; DRAIN->IDLE when output buffer empty.
REQ-020 Output buffer: 2-entry FIFO capturing gb_rd_data one cycle after each gb_rd_en; out_data/out_valid driven from FIFO head (registered, no combinational path from out_ready to out_data).
REQ-021 gb_rd_en asserted only if FIFO occupancy plus reads in flight < 2; no element is ever dropped or duplicated under arbitrary out_ready.
REQ-022 Throughput: with out_ready held high, one element per cycle; first out_valid 2 cycles after accepted start.
REQ-023 out_last travels with its element through the FIFO; asserted for element index vec_len-1 of every pass.
REQ-024 Element order per pass strictly ascending address; pass counter increments on last read of each pass.
REQ-025 start while busy ignored; vec_len/num_passes changes mid-job have no effect.
REQ-026 out_valid, once high, holds with stable out_data/out_last until accepted.
REQ-027 done asserted the cycle after the final handshake; busy deasserts the same cycle done asserts.

Reset
REQ-028 rst_n low asynchronously: state IDLE, counters 0, FIFO empty, gb_rd_en/gb_rd_addr/out_valid/out_data/out_last/busy/done all 0.
REQ-029 Reset mid-job aborts; any read in flight at reset is discarded; no output until new start.

Structure
REQ-030 Shared package holds DATA_WIDTH, GB_ADDR_WIDTH, VEC_LEN_MAX=100, state encoding constants.
REQ-031 One sub-module: gb_rd_skid_fifo (2-entry, data+last, valid/ready both sides).

Verification
REQ-032 Preload addr 0..99 with repeating 0x0080,0x0020,0x0040,0x0100,0x00A0; start vec_len=100, num_passes=1, out_ready=1 -> 100 elements in order, first 0x0080 at cycle 2, out_last only on element 99 (0x00A0), done 1 cycle later.
REQ-033 Same preload, vec_len=5, num_passes=3 -> 15 elements, pattern repeated 3x, out_last on elements 4, 9, 14.
REQ-034 vec_len=10, out_ready toggling 1-0 every cycle and random bursts low -> exact sequence 0x0080..0x00A0 x2, no loss/duplication, out_data stable while stalled, gb_rd_en never causes FIFO overflow.
REQ-035 vec_len=1, num_passes=1 -> single element 0x0080 with out_last=1; start pulsed again during busy -> ignored.
REQ-036 vec_len=100, rst_n low after 37 accepted elements -> all outputs 0 immediately; new start replays from addr 0.
REQ-037 start with vec_len=0 -> no gb_rd_en, no out_valid, done pulse next cycle.
